// File: rtl/phase_error_counter_if.sv
// phase_error_counter_if: count/capture handshake between the ADPLL phase detector and the error counter.
interface phase_error_counter_if #(
    parameter int COUNT_WIDTH = 16
);
    logic [1:0]             count_instr_i;
    logic                   save_and_clear_i;
    logic                   counter_cleared_o;
    logic [COUNT_WIDTH-1:0] phase_error_o;
    logic                   phase_error_valid_o;
    logic                   saturated_o;

    modport master (
        output count_instr_i, save_and_clear_i,
        input  counter_cleared_o, phase_error_o, phase_error_valid_o, saturated_o
    );

    modport slave (
        input  count_instr_i, save_and_clear_i,
        output counter_cleared_o, phase_error_o, phase_error_valid_o, saturated_o
    );
endinterface

// File: rtl/phase_error_counter.sv
// phase_error_counter: saturating signed up/down cycle counter with save-and-clear capture handshake.
module phase_error_counter #(
    parameter int COUNT_WIDTH = 16
) (
    input logic                  fpga_clk_i,
    input logic                  reset_i,
    phase_error_counter_if.slave bus
);
    localparam logic [COUNT_WIDTH-1:0] MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
    localparam logic [COUNT_WIDTH-1:0] MIN = {1'b1, {(COUNT_WIDTH-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {RUN = 2'b01, ACK = 2'b10} state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic [COUNT_WIDTH-1:0] pe_q, pe_d;
    logic                   valid_q, valid_d;
    logic                   sat_out_q, sat_out_d;
    logic [COUNT_WIDTH-1:0] inc, dec;
    logic                   up, dn, at_max, at_min, capture;

    assign up      = bus.count_instr_i == 2'b01;
    assign dn      = bus.count_instr_i == 2'b10;
    assign inc     = cnt_q + 1'b1;
    assign dec     = cnt_q - 1'b1;
    assign at_max  = cnt_q == MAX;
    assign at_min  = cnt_q == MIN;
    assign capture = state_q == RUN && bus.save_and_clear_i;

    // Capture takes the pre-instruction count and discards this cycle's instruction.
    always_comb begin
        state_d   = state_q == RUN ? (bus.save_and_clear_i ? ACK : RUN)
                                   : (bus.save_and_clear_i ? ACK : RUN);
        cnt_d     = up ? (at_max ? cnt_q : inc) : dn ? (at_min ? cnt_q : dec) : cnt_q;
        sat_d     = sat_q | (up && (at_max || inc == MAX)) | (dn && (at_min || dec == MIN));
        pe_d      = capture ? cnt_q : pe_q;
        sat_out_d = capture ? sat_q : sat_out_q;
        valid_d   = capture;
        if (capture) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            pe_q      <= '0;
            valid_q   <= 1'b0;
            sat_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            pe_q      <= pe_d;
            valid_q   <= valid_d;
            sat_out_q <= sat_out_d;
        end
    end

    assign bus.counter_cleared_o   = state_q == ACK;
    assign bus.phase_error_o       = pe_q;
    assign bus.phase_error_valid_o = valid_q;
    assign bus.saturated_o         = sat_out_q;
endmodule

// File: tb/tb_phase_error_counter.sv
// tb_phase_error_counter: directed checks of a 16-bit and a 4-bit counter against hand-computed results.
module tb_phase_error_counter;
    logic fpga_clk = 1'b0;
    logic rst      = 1'b1;
    int   total    = 0;
    int   fails    = 0;
    int   pulses;

    phase_error_counter_if #(.COUNT_WIDTH(16)) a ();
    phase_error_counter_if #(.COUNT_WIDTH(4))  b ();

    phase_error_counter #(.COUNT_WIDTH(16)) dut_a (.fpga_clk_i(fpga_clk), .reset_i(rst), .bus(a));
    phase_error_counter #(.COUNT_WIDTH(4))  dut_b (.fpga_clk_i(fpga_clk), .reset_i(rst), .bus(b));

    always #5 fpga_clk = ~fpga_clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge fpga_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [15:0] pe, input logic v, input logic s, input logic c);
        chk({tag, ".pe"}, {16'h0, a.phase_error_o}, {16'h0, pe});
        chk({tag, ".valid"}, {31'h0, a.phase_error_valid_o}, {31'h0, v});
        chk({tag, ".sat"}, {31'h0, a.saturated_o}, {31'h0, s});
        chk({tag, ".cleared"}, {31'h0, a.counter_cleared_o}, {31'h0, c});
    endtask

    task automatic chk_b(input string tag, input logic [3:0] pe, input logic v, input logic s);
        chk({tag, ".pe"}, {28'h0, b.phase_error_o}, {28'h0, pe});
        chk({tag, ".valid"}, {31'h0, b.phase_error_valid_o}, {31'h0, v});
        chk({tag, ".sat"}, {31'h0, b.saturated_o}, {31'h0, s});
    endtask

    initial begin
        a.count_instr_i = 2'b00; a.save_and_clear_i = 1'b0;
        b.count_instr_i = 2'b00; b.save_and_clear_i = 1'b0;
        tick(2);
        chk_a("reset_a", 16'h0, 0, 0, 0);
        chk_b("reset_b", 4'h0, 0, 0);
        rst = 1'b0;
        // up 10, save held 2 cycles
        a.count_instr_i = 2'b01; tick(10);
        a.count_instr_i = 2'b00; a.save_and_clear_i = 1'b1; tick(1);
        chk_a("up10_cap", 16'd10, 1, 0, 1);
        tick(1);
        chk_a("up10_hold", 16'd10, 0, 0, 1);
        a.save_and_clear_i = 1'b0; tick(1);
        chk_a("up10_rel", 16'd10, 0, 0, 0);
        // back-to-back capture in first RUN cycle shows cnt was cleared
        a.save_and_clear_i = 1'b1; tick(1);
        chk_a("b2b_cap", 16'd0, 1, 0, 1);
        a.save_and_clear_i = 1'b0; tick(1);
        // down 5
        a.count_instr_i = 2'b10; tick(5);
        a.count_instr_i = 2'b00; a.save_and_clear_i = 1'b1; tick(1);
        chk_a("dn5_cap", 16'hFFFB, 1, 0, 1);
        a.save_and_clear_i = 1'b0; tick(1);
        // save held 6 cycles while counting up
        a.count_instr_i = 2'b01; tick(3);
        a.save_and_clear_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            pulses += int'(a.phase_error_valid_o);
        end
        chk("hold6_pulses", pulses, 1);
        chk_a("hold6_end", 16'd3, 0, 0, 1);
        a.save_and_clear_i = 1'b0; a.count_instr_i = 2'b00; tick(1);
        chk_a("hold6_rel", 16'd3, 0, 0, 0);
        a.save_and_clear_i = 1'b1; tick(1);
        chk_a("ack_count", 16'd5, 1, 0, 1);
        a.save_and_clear_i = 1'b0; tick(1);
        // illegal instruction holds
        a.count_instr_i = 2'b11; tick(8);
        a.count_instr_i = 2'b00; a.save_and_clear_i = 1'b1; tick(1);
        chk_a("illegal_cap", 16'd0, 1, 0, 1);
        a.save_and_clear_i = 1'b0; tick(1);
        // reset during ACK
        a.count_instr_i = 2'b01; tick(4);
        a.count_instr_i = 2'b00; a.save_and_clear_i = 1'b1; tick(1);
        chk_a("pre_rst_cap", 16'd4, 1, 0, 1);
        rst = 1'b1; tick(1);
        chk_a("rst_ack", 16'd0, 0, 0, 0);
        rst = 1'b0; a.save_and_clear_i = 1'b0; tick(1);
        chk_a("post_rst", 16'd0, 0, 0, 0);
        a.save_and_clear_i = 1'b1; tick(1);
        chk_a("post_rst_cap", 16'd0, 1, 0, 1);
        a.save_and_clear_i = 1'b0; tick(1);
        // 4-bit: saturation at both limits and exact-reach boundaries
        b.count_instr_i = 2'b01; tick(20);
        b.count_instr_i = 2'b00; b.save_and_clear_i = 1'b1; tick(1);
        chk_b("w4_up20", 4'd7, 1, 1);
        b.save_and_clear_i = 1'b0; tick(1);
        b.count_instr_i = 2'b10; tick(3);
        b.count_instr_i = 2'b00; b.save_and_clear_i = 1'b1; tick(1);
        chk_b("w4_dn3", 4'hD, 1, 0);
        b.save_and_clear_i = 1'b0; tick(1);
        b.count_instr_i = 2'b10; tick(10);
        b.count_instr_i = 2'b00; b.save_and_clear_i = 1'b1; tick(1);
        chk_b("w4_dn10", 4'h9, 1, 1);
        b.save_and_clear_i = 1'b0; tick(1);
        b.count_instr_i = 2'b01; tick(7);
        b.count_instr_i = 2'b00; b.save_and_clear_i = 1'b1; tick(1);
        chk_b("w4_up7", 4'd7, 1, 1);
        b.save_and_clear_i = 1'b0; tick(1);
        b.count_instr_i = 2'b01; tick(6);
        b.count_instr_i = 2'b00; b.save_and_clear_i = 1'b1; tick(1);
        chk_b("w4_up6", 4'd6, 1, 0);
        b.save_and_clear_i = 1'b0; tick(1);
        chk_b("w4_idle", 4'd6, 0, 0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
